nes_cart_bus_driver: RTL

- Host-side counterpart to our cartridge mappers: turns simple host requests into NES CPU bus cycles (M2, /ROMSEL, R/W, A14..0, D7..0).
- Generates PPU A12 rising-edge trains to exercise scanline IRQ counters.
- Watches the cartridge /IRQ line.
- Sits in the cartridge tester/dumper top level, directly facing the cartridge connector.

---
 rtl/nes_bus_pkg.sv | 16 +
 rtl/nes_a12_stim.sv | 64 ++++++
 rtl/nes_cart_bus_driver.sv | 136 +++++++++++++
 3 files changed

// File: rtl/nes_bus_pkg.sv
// Shared definitions for the NES cartridge bus driver: bus-cycle states and
// fixed constants used by the bus sequencer and the A12 stimulus generator.
package nes_bus_pkg;

    typedef enum logic [2:0] {
        IDLE_LO,
        IDLE_HI,
        XFER_LO,
        XFER_HI,
        HOLD
    } bus_state_t;

    localparam int DIV_MIN = 2;
    localparam logic [15:0] IDLE_ADDR = 16'h0000;

endpackage

// File: rtl/nes_a12_stim.sv
// PPU A12 rising-edge train generator, paced by M2 rising edges so that the
// low and high periods are whole M2 cycles.
module nes_a12_stim
    import nes_bus_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       m2_rise,
    input  logic       start,
    input  logic [7:0] count,
    input  logic [3:0] low,
    output logic       a12,
    output logic       busy,
    output logic       done
);

    logic [7:0] edges_left;
    logic [4:0] low_left;
    logic [3:0] low_q;
    logic [3:0] low_eff;

    assign low_eff = (low == 4'd0) ? 4'd1 : low;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a12        <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            edges_left <= 8'd0;
            low_left   <= 5'd0;
            low_q      <= 4'd1;
        end else begin
            done <= 1'b0;
            if (!busy) begin
                if (start) begin
                    if (count == 8'd0) begin
                        done <= 1'b1;
                    end else begin
                        busy       <= 1'b1;
                        edges_left <= count;
                        low_q      <= low_eff;
                        // One extra M2 rise absorbs the partial cycle in which start arrived.
                        low_left   <= {1'b0, low_eff} + 5'd1;
                    end
                end
            end else if (m2_rise) begin
                if (a12) begin
                    a12        <= 1'b0;
                    low_left   <= {1'b0, low_q};
                    edges_left <= edges_left - 8'd1;
                    if (edges_left == 8'd1) begin
                        busy <= 1'b0;
                        done <= 1'b1;
                    end
                end else if (low_left == 5'd1) begin
                    a12 <= 1'b1;
                end else begin
                    low_left <= low_left - 5'd1;
                end
            end
        end
    end

endmodule

// File: rtl/nes_cart_bus_driver.sv
// Host-side NES CPU bus cycle generator for cartridge testing: M2/ROMSEL/R/W
// sequencing, PPU A12 edge trains and a sticky /IRQ monitor.
module nes_cart_bus_driver
    import nes_bus_pkg::*;
#(
    parameter int DIV         = 6,
    parameter int SYNC_STAGES = 2
)
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        host_req,
    output logic        host_ready,
    input  logic        host_rw,
    input  logic [15:0] host_addr,
    input  logic [7:0]  host_wdata,
    output logic [7:0]  host_rdata,
    output logic        host_ack,
    output logic        m2,
    output logic        romsel,
    output logic        cpu_rw,
    output logic [14:0] cpu_addr,
    output logic [7:0]  cpu_data_out,
    output logic        cpu_data_oe,
    input  logic [7:0]  cpu_data_in,
    output logic        ppu_a12,
    input  logic        a12_start,
    input  logic [7:0]  a12_count,
    input  logic [3:0]  a12_low,
    output logic        a12_busy,
    output logic        a12_done,
    input  logic        irq_n,
    output logic        irq_seen,
    input  logic        irq_clear
);

    localparam int DIV_EFF  = (DIV < DIV_MIN) ? DIV_MIN : DIV;
    localparam int SYNC_EFF = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
    localparam int CW       = $clog2(DIV_EFF);
    localparam logic [CW-1:0] LAST = CW'(DIV_EFF - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    bus_state_t    state, nxt_state;
    logic [CW-1:0] cnt, nxt_cnt;
    logic [15:0]   xfer_addr;
    logic          xfer_rw;
    logic [7:0]    xfer_wdata;
    logic          take, m2_rise, nxt_oe;
    logic [SYNC_EFF-1:0] irq_sync;

    always_comb begin
        nxt_state = state;
        nxt_cnt   = cnt + ONE;
        case (state)
            IDLE_LO: if (cnt == LAST) begin nxt_state = IDLE_HI; nxt_cnt = '0; end
            IDLE_HI: if (cnt == LAST) begin nxt_state = host_req ? XFER_LO : IDLE_LO; nxt_cnt = '0; end
            XFER_LO: if (cnt == LAST) begin nxt_state = XFER_HI; nxt_cnt = '0; end
            XFER_HI: if (cnt == LAST) begin nxt_state = HOLD; nxt_cnt = '0; end
            // HOLD is the first LOW clock of the following cycle.
            HOLD:    begin nxt_state = IDLE_LO; nxt_cnt = ONE; end
            default: begin nxt_state = IDLE_LO; nxt_cnt = '0; end
        endcase
    end

    assign take    = (state == IDLE_HI) && (cnt == LAST) && host_req;
    assign m2_rise = ((state == IDLE_LO) || (state == XFER_LO)) && (cnt == LAST);
    assign nxt_oe  = !xfer_rw && (((nxt_state == XFER_LO) && (nxt_cnt != '0)) ||
                                  (nxt_state == XFER_HI) || (nxt_state == HOLD));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE_LO;
            cnt          <= '0;
            m2           <= 1'b0;
            romsel       <= 1'b1;
            cpu_rw       <= 1'b1;
            cpu_addr     <= IDLE_ADDR[14:0];
            cpu_data_out <= 8'h00;
            cpu_data_oe  <= 1'b0;
            host_ack     <= 1'b0;
            host_rdata   <= 8'h00;
            host_ready   <= 1'b0;
            xfer_addr    <= IDLE_ADDR;
            xfer_rw      <= 1'b1;
            xfer_wdata   <= 8'h00;
        end else begin
            state        <= nxt_state;
            cnt          <= nxt_cnt;
            m2           <= (nxt_state == IDLE_HI) || (nxt_state == XFER_HI);
            romsel       <= !((nxt_state == XFER_HI) && xfer_addr[15]);
            host_ready   <= (nxt_state == IDLE_LO) && (nxt_cnt == LAST);
            host_ack     <= (state == XFER_HI) && (nxt_state == HOLD);
            cpu_data_oe  <= nxt_oe;
            cpu_data_out <= nxt_oe ? xfer_wdata : 8'h00;
            if ((state == XFER_HI) && (nxt_state == HOLD) && xfer_rw)
                host_rdata <= cpu_data_in;
            if (take) begin
                xfer_addr  <= host_addr;
                xfer_rw    <= host_rw;
                xfer_wdata <= host_wdata;
                cpu_addr   <= host_addr[14:0];
                cpu_rw     <= host_rw;
            end else if ((nxt_state == IDLE_LO) || (nxt_state == IDLE_HI)) begin
                cpu_addr   <= IDLE_ADDR[14:0];
                cpu_rw     <= 1'b1;
            end
        end
    end

    // /IRQ is asynchronous to clk; a held-low line keeps the flag set over a clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            irq_sync <= '1;
            irq_seen <= 1'b0;
        end else begin
            irq_sync <= {irq_sync[SYNC_EFF-2:0], irq_n};
            if (!irq_sync[SYNC_EFF-1])
                irq_seen <= 1'b1;
            else if (irq_clear)
                irq_seen <= 1'b0;
        end
    end

    nes_a12_stim u_a12 (
        .clk     (clk),
        .rst_n   (rst_n),
        .m2_rise (m2_rise),
        .start   (a12_start),
        .count   (a12_count),
        .low     (a12_low),
        .a12     (ppu_a12),
        .busy    (a12_busy),
        .done    (a12_done)
    );

endmodule
